// File: rtl/avalon_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package avalon_multi_timer_pkg;

  // Per-channel register offsets within the 8-word channel window.
  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD_L = 3'd2,
    REG_PERIOD_H = 3'd3,
    REG_SNAP_L   = 3'd4,
    REG_SNAP_H   = 3'd5,
    REG_PRESCALE = 3'd6,
    REG_RSVD     = 3'd7
  } reg_off_e;

  // Control register bit positions.
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Status register bit positions.
  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

endpackage

// File: rtl/avalon_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
interface avalon_multi_timer_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_multi_timer_channel.sv
// One timer channel: registers, prescaler, down-counter, snapshot and TO/RUN flags.
module avalon_multi_timer_channel
  import avalon_multi_timer_pkg::*;
#(
  parameter int COUNT_W      = 32,
  parameter int RESET_PERIOD = 11999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  reg_off_e    offset,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq
);

  logic [3:0]         ctrl_q, ctrl_d;
  logic [COUNT_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0] counter_q, counter_d;
  logic [COUNT_W-1:0] snap_q, snap_d;
  logic [15:0]        prescale_q, prescale_d;
  logic [15:0]        pcnt_q, pcnt_d;
  logic               run_q, run_d;
  logic               to_q, to_d;
  logic               reload_q, reload_d;
  logic               tick, timeout, start, stop;

  // Next-state: register writes, prescaler, counter, then event priorities
  // (force_reload over START, START over STOP, status clear over timeout).
  always_comb begin
    ctrl_d     = ctrl_q;
    period_d   = period_q;
    counter_d  = counter_q;
    snap_d     = snap_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    run_d      = run_q;
    to_d       = to_q;
    reload_d   = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    timeout    = 1'b0;
    tick       = (pcnt_q == 16'd0);

    if (wr_en) begin
      case (offset)
        REG_CONTROL: begin
          ctrl_d = wdata[3:0];
          start  = wdata[CTRL_START];
          stop   = wdata[CTRL_STOP];
        end
        REG_PERIOD_L: begin
          period_d[15:0] = wdata;
          reload_d       = 1'b1;
        end
        REG_PERIOD_H: begin
          period_d[COUNT_W-1:16] = wdata[COUNT_W-17:0];
          reload_d               = 1'b1;
        end
        REG_SNAP_L, REG_SNAP_H: snap_d = counter_q;
        REG_PRESCALE:           prescale_d = wdata;
        default: ;
      endcase
    end

    if (run_q) begin
      pcnt_d = tick ? prescale_q : pcnt_q - 16'd1;
      if (tick) begin
        if (counter_q == '0) begin
          counter_d = period_q;
          timeout   = 1'b1;
        end else begin
          counter_d = counter_q - COUNT_W'(1);
        end
      end
    end

    if (timeout) begin
      to_d = 1'b1;
      if (!ctrl_q[CTRL_CONT]) run_d = 1'b0;
    end
    if (stop) run_d = 1'b0;
    if (start) begin
      run_d  = 1'b1;
      pcnt_d = prescale_q;
    end
    if (reload_q) begin
      counter_d = period_q;
      run_d     = 1'b0;
    end
    if (wr_en && offset == REG_STATUS) to_d = 1'b0;
  end

  // Read word for the addressed offset; upper halves are zero-extended.
  always_comb begin
    rdata = '0;
    case (offset)
      REG_STATUS: begin
        rdata[STAT_RUN] = run_q;
        rdata[STAT_TO]  = to_q;
      end
      REG_CONTROL:  rdata[3:0] = ctrl_q;
      REG_PERIOD_L: rdata = period_q[15:0];
      REG_PERIOD_H: rdata = 16'(period_q[COUNT_W-1:16]);
      REG_SNAP_L:   rdata = snap_q[15:0];
      REG_SNAP_H:   rdata = 16'(snap_q[COUNT_W-1:16]);
      REG_PRESCALE: rdata = prescale_q;
      default:      rdata = '0;
    endcase
  end

  assign irq = to_q && ctrl_q[CTRL_ITO];

  // Channel state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      period_q   <= COUNT_W'(RESET_PERIOD);
      counter_q  <= COUNT_W'(RESET_PERIOD);
      snap_q     <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      run_q      <= 1'b0;
      to_q       <= 1'b0;
      reload_q   <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      counter_q  <= counter_d;
      snap_q     <= snap_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      run_q      <= run_d;
      to_q       <= to_d;
      reload_q   <= reload_d;
    end
  end

endmodule

// File: rtl/avalon_multi_timer.sv
// Multi-channel Avalon-MM interval timer: channel decode, read mux and irq merge.
module avalon_multi_timer
  import avalon_multi_timer_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int COUNT_W      = 32,
  parameter int RESET_PERIOD = 11999
) (
  input  logic              clk,
  input  logic              reset_n,
  avalon_multi_timer_if.slave bus,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam int ADDR_W = 3 + $clog2(NUM_CH);

  logic [ADDR_W-1:0] ch_idx;
  reg_off_e          offset;
  logic              wr_req;
  logic [NUM_CH-1:0] ch_wr;
  logic [15:0]       ch_rdata [NUM_CH];
  logic [15:0]       readdata_q, readdata_d;

  assign ch_idx = bus.address >> 3;
  assign offset = reg_off_e'(bus.address[2:0]);
  assign wr_req = bus.chipselect && !bus.write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_wr[i] = wr_req && (ch_idx == ADDR_W'(i));

    avalon_multi_timer_channel #(
      .COUNT_W      (COUNT_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (ch_wr[i]),
      .offset  (offset),
      .wdata   (bus.writedata),
      .rdata   (ch_rdata[i]),
      .irq     (irq_vec[i])
    );
  end

  // Select the addressed channel's read word; unpopulated channels read 0.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == ADDR_W'(i)) readdata_d = ch_rdata[i];
    end
  end

  // Register read data every clock, giving one cycle of read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign bus.readdata = readdata_q;
  assign irq          = |irq_vec;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Self-checking bench for avalon_multi_timer: register table plus timing sequences.
module tb_avalon_multi_timer;
  localparam int NUM_CH       = 3;
  localparam int COUNT_W      = 32;
  localparam int RESET_PERIOD = 11999;
  localparam int ADDR_W       = 3 + $clog2(NUM_CH);
  localparam int NUM_VECS     = 22;

  typedef struct {
    bit          wr;
    int          ch;
    int          off;
    logic [15:0] data;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;
  int                vec_count = 0;
  int                miss_count = 0;
  vec_t              vecs [NUM_VECS];

  avalon_multi_timer_if #(.ADDR_W(ADDR_W)) bus ();

  avalon_multi_timer #(
    .NUM_CH       (NUM_CH),
    .COUNT_W      (COUNT_W),
    .RESET_PERIOD (RESET_PERIOD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq),
    .irq_vec (irq_vec)
  );

  always #5 clk = ~clk;

  // One bus cycle starting at a falling edge; write strobes or read address.
  task automatic applyStimulus(input bit wr, input int ch, input int off,
                               input logic [15:0] wdata, output logic [15:0] rdata);
    bus.address    = ADDR_W'((ch << 3) | off);
    bus.chipselect = wr;
    bus.write_n    = !wr;
    bus.writedata  = wr ? wdata : 16'h0000;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    rdata          = bus.readdata;
  endtask

  task automatic writeReg(input int ch, input int off, input logic [15:0] wdata);
    logic [15:0] unused_rd;
    applyStimulus(1'b1, ch, off, wdata, unused_rd);
  endtask

  task automatic readReg(input int ch, input int off, output logic [15:0] rdata);
    applyStimulus(1'b0, ch, off, 16'h0000, rdata);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkNear(input string name, input logic [31:0] actual,
                           input logic [31:0] lo, input logic [31:0] hi);
    vec_count++;
    if (actual < lo || actual > hi) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Counts falling edges until irq_vec[ch] rises, giving up after limit.
  task automatic waitIrq(input int ch, input int limit, output int cycles);
    cycles = 0;
    while (!irq_vec[ch] && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    logic [15:0] rd;
    int          n;

    vecs[0]  = '{1'b0, 0, 2, 16'd11999};
    vecs[1]  = '{1'b0, 0, 3, 16'h0000};
    vecs[2]  = '{1'b0, 0, 0, 16'h0000};
    vecs[3]  = '{1'b0, 0, 1, 16'h0000};
    vecs[4]  = '{1'b0, 1, 2, 16'd11999};
    vecs[5]  = '{1'b0, 0, 4, 16'h0000};
    vecs[6]  = '{1'b0, 0, 6, 16'h0000};
    vecs[7]  = '{1'b1, 1, 6, 16'h1234};
    vecs[8]  = '{1'b0, 1, 6, 16'h1234};
    vecs[9]  = '{1'b1, 3, 2, 16'h0055};
    vecs[10] = '{1'b0, 3, 2, 16'h0000};
    vecs[11] = '{1'b0, 0, 2, 16'd11999};
    vecs[12] = '{1'b0, 2, 2, 16'd11999};
    vecs[13] = '{1'b1, 0, 7, 16'hFFFF};
    vecs[14] = '{1'b0, 0, 7, 16'h0000};
    vecs[15] = '{1'b1, 1, 2, 16'hABCD};
    vecs[16] = '{1'b0, 1, 2, 16'hABCD};
    vecs[17] = '{1'b1, 1, 3, 16'h0001};
    vecs[18] = '{1'b0, 1, 3, 16'h0001};
    vecs[19] = '{1'b1, 1, 1, 16'h0003};
    vecs[20] = '{1'b0, 1, 1, 16'h0003};
    vecs[21] = '{1'b0, 3, 0, 16'h0000};

    reset_n        = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset irq", irq, 0);
    checkOutput("reset irq_vec", irq_vec, 0);
    checkOutput("reset readdata", bus.readdata, 0);
    reset_n = 1'b1;

    // Register map, reset values and out-of-range channel accesses.
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].ch, vecs[i].off, vecs[i].data, rd);
      if (!vecs[i].wr)
        checkOutput($sformatf("vec%0d ch%0d off%0d", i, vecs[i].ch, vecs[i].off),
                    rd, vecs[i].data);
    end

    // ch0 continuous, period 9, no prescale: timeout every 10 clocks.
    writeReg(0, 2, 16'd9);
    writeReg(0, 3, 16'd0);
    writeReg(0, 6, 16'd0);
    writeReg(0, 1, 16'h7);
    waitIrq(0, 50, n);
    checkOutput("ch0 first timeout clocks", n, 10);
    writeReg(0, 0, 16'h0);
    checkOutput("ch0 irq after clear", irq_vec[0], 0);
    readReg(0, 0, rd);
    checkOutput("ch0 status running", rd, 16'h2);
    waitIrq(0, 50, n);
    checkOutput("ch0 second timeout clocks", n, 8);
    writeReg(0, 0, 16'h0);
    waitIrq(0, 50, n);
    checkOutput("ch0 third timeout clocks", n, 9);
    writeReg(0, 1, 16'h8);
    writeReg(0, 0, 16'h0);
    readReg(0, 0, rd);
    checkOutput("ch0 status stopped", rd, 16'h0);
    readReg(0, 1, rd);
    checkOutput("ch0 control readback", rd, 16'h8);

    // ch1 one-shot, period 3, prescale 4: timeout after 20 clocks then stop.
    writeReg(1, 2, 16'd3);
    writeReg(1, 3, 16'd0);
    writeReg(1, 6, 16'd4);
    writeReg(1, 1, 16'h5);
    waitIrq(1, 60, n);
    checkOutput("ch1 one-shot clocks", n, 20);
    readReg(1, 0, rd);
    checkOutput("ch1 status after one-shot", rd, 16'h1);
    checkOutput("ch1 combined irq", irq, 1);
    repeat (10) @(negedge clk);
    readReg(1, 0, rd);
    checkOutput("ch1 stays stopped", rd, 16'h1);
    writeReg(1, 4, 16'h0);
    readReg(1, 4, rd);
    checkOutput("ch1 counter holds period", rd, 16'd3);
    readReg(1, 5, rd);
    checkOutput("ch1 snap_h", rd, 16'd0);
    writeReg(1, 0, 16'h0);
    checkOutput("ch1 irq after clear", irq, 0);

    // ch0 period 100: START beside force_reload loses, snapshot, period rewrite.
    writeReg(0, 2, 16'd100);
    writeReg(0, 3, 16'd0);
    writeReg(0, 1, 16'h6);
    readReg(0, 0, rd);
    checkOutput("ch0 start lost to reload", rd, 16'h0);
    writeReg(0, 1, 16'h6);
    repeat (60) @(negedge clk);
    writeReg(0, 4, 16'h0);
    readReg(0, 4, rd);
    checkNear("ch0 snap_l at 40", rd, 39, 41);
    readReg(0, 5, rd);
    checkOutput("ch0 snap_h at 40", rd, 16'd0);
    writeReg(0, 2, 16'd50);
    @(negedge clk);
    readReg(0, 0, rd);
    checkOutput("ch0 run cleared by period write", rd, 16'h0);
    writeReg(0, 4, 16'h0);
    readReg(0, 4, rd);
    checkOutput("ch0 counter reloaded to 50", rd, 16'd50);
    readReg(0, 2, rd);
    checkOutput("ch0 period_l 50", rd, 16'd50);

    // START+STOP together starts; status clear coinciding with timeout wins.
    writeReg(0, 1, 16'hC);
    readReg(0, 0, rd);
    checkOutput("ch0 START beats STOP", rd, 16'h2);
    repeat (49) @(negedge clk);
    writeReg(0, 0, 16'h0);
    readReg(0, 0, rd);
    checkOutput("ch0 clear beats timeout", rd, 16'h0);
    readReg(0, 1, rd);
    checkOutput("ch0 control strobes read back", rd, 16'hC);

    // Reset asserted while ch1 is counting with its interrupt raised.
    writeReg(1, 1, 16'h7);
    waitIrq(1, 100, n);
    checkOutput("ch1 continuous first timeout", n, 20);
    readReg(1, 2, rd);
    checkOutput("ch1 period before reset", rd, 16'd3);
    checkOutput("irq before reset", irq, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid-count reset irq", irq, 0);
    checkOutput("mid-count reset irq_vec", irq_vec, 0);
    checkOutput("mid-count reset readdata", bus.readdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    readReg(1, 2, rd);
    checkOutput("ch1 period after reset", rd, 16'd11999);
    readReg(1, 0, rd);
    checkOutput("ch1 status after reset", rd, 16'h0);
    checkOutput("irq after reset", irq, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
